// File: rtl/cus43_mixer_if.sv
// cus43_mixer_if: fetch, attribute, chain and output bundle for the mixer.
// MASK_A/MASK_B exist only when CUS43_LAYER_MASK_EN is defined.
interface cus43_mixer_if #(
  parameter int COLOR_W = 8
);
  logic                 CLK_2H;
  logic                 FLIP;
  logic [11:0]          GD;
  logic [COLOR_W-1:0]   RD;
  logic [1:0]           FINE_A;
  logic [1:0]           FINE_B;
  logic [2:0]           PRIA;
  logic [2:0]           PRIB;
  logic [COLOR_W+2:0]   COL_IN;
  logic [2:0]           PRI_IN;
  logic                 OPQ_IN;
  logic [COLOR_W+2:0]   COL_OUT;
  logic [2:0]           PRI_OUT;
  logic                 OPQ_OUT;
`ifdef CUS43_LAYER_MASK_EN
  logic                 MASK_A;
  logic                 MASK_B;
`endif

  modport master (
`ifdef CUS43_LAYER_MASK_EN
    output MASK_A, MASK_B,
`endif
    output CLK_2H, FLIP, GD, RD,
    output FINE_A, FINE_B, PRIA, PRIB,
    output COL_IN, PRI_IN, OPQ_IN,
    input  COL_OUT, PRI_OUT, OPQ_OUT
  );

  modport slave (
`ifdef CUS43_LAYER_MASK_EN
    input  MASK_A, MASK_B,
`endif
    input  CLK_2H, FLIP, GD, RD,
    input  FINE_A, FINE_B, PRIA, PRIB,
    input  COL_IN, PRI_IN, OPQ_IN,
    output COL_OUT, PRI_OUT, OPQ_OUT
  );
endinterface

// File: rtl/cus43_mixer.sv
// cus43_mixer: tile pixel serialiser and two-layer priority mixer.
// Optional per-layer debug masks under CUS43_LAYER_MASK_EN.
module cus43_mixer #(
  parameter logic [2:0] TRANSPARENT_PEN = 3'd7,
  parameter int         COLOR_W         = 8
) (
  input logic          CLK_6M,
  input logic          rst,
  cus43_mixer_if.slave bus
);
  localparam int PW = COLOR_W + 3;
  localparam logic [11:0] TP4 = {4{TRANSPARENT_PEN}};

  typedef struct packed {
    logic [11:0]        lat;
    logic [11:0]        cur;
    logic [11:0]        nxt;
    logic [COLOR_W-1:0] atr;
    logic [COLOR_W-1:0] catr;
    logic [COLOR_W-1:0] natr;
  } layer_t;

  localparam layer_t LRST = '{
    lat: TP4, cur: TP4, nxt: TP4,
    atr: '0, catr: '0, natr: '0
  };

  // 8-pen window {nxt, cur}; flip reverses pens inside each group
  function automatic logic [PW-1:0] pick(
    input layer_t     l,
    input logic [1:0] fine,
    input logic [1:0] ph,
    input logic       fl
  );
    logic [2:0]  idx;
    logic [1:0]  j;
    logic [11:0] g;
    idx = {1'b0, ph} + {1'b0, fine};
    j   = fl ? ~idx[1:0] : idx[1:0];
    g   = (idx[2] ? l.nxt : l.cur) >> (4'(j) * 4'd3);
    return {idx[2] ? l.natr : l.catr, g[2:0]};
  endfunction

  logic          c2h_d_q;
  logic [1:0]    phase_q, phase_d;
  layer_t        layA_q, layA_d;
  layer_t        layB_q, layB_d;
  logic [PW-1:0] col_q, col_d;
  logic [2:0]    pri_q, pri_d;
  logic          opq_q, opq_d;

  logic [PW-1:0] pxA, pxB, cand_col;
  logic [2:0]    cand_pri;
  logic          opA, opB, selA, selB, win;

  always_comb begin
    layA_d  = layA_q;
    layB_d  = layB_q;
    phase_d = phase_q + 2'd1;
    if (!bus.CLK_2H && !c2h_d_q) begin
      layA_d.lat = bus.GD;
      layA_d.atr = bus.RD;
    end
    if (bus.CLK_2H && c2h_d_q) begin
      layB_d.lat = bus.GD;
      layB_d.atr = bus.RD;
    end
    if (c2h_d_q && !bus.CLK_2H) begin
      layA_d.cur  = layA_q.nxt;
      layA_d.nxt  = layA_q.lat;
      layA_d.catr = layA_q.natr;
      layA_d.natr = layA_q.atr;
      layB_d.cur  = layB_q.nxt;
      layB_d.nxt  = layB_q.lat;
      layB_d.catr = layB_q.natr;
      layB_d.natr = layB_q.atr;
      phase_d     = 2'd0;
    end
  end

  assign pxA = pick(layA_q, bus.FINE_A, phase_q, bus.FLIP);
  assign pxB = pick(layB_q, bus.FINE_B, phase_q, bus.FLIP);

`ifdef CUS43_LAYER_MASK_EN
  assign opA = (pxA[2:0] != TRANSPARENT_PEN) && !bus.MASK_A;
  assign opB = (pxB[2:0] != TRANSPARENT_PEN) && !bus.MASK_B;
`else
  assign opA = pxA[2:0] != TRANSPARENT_PEN;
  assign opB = pxB[2:0] != TRANSPARENT_PEN;
`endif

  assign selA = opA && (!opB || bus.PRIA >= bus.PRIB);
  assign selB = !selA && opB;

  always_comb begin
    cand_col = '0;
    cand_pri = '0;
    unique case (1'b1)
      selA: begin
        cand_col = pxA;
        cand_pri = bus.PRIA;
      end
      selB: begin
        cand_col = pxB;
        cand_pri = bus.PRIB;
      end
      default: ;
    endcase
    win = (selA || selB) &&
          (!bus.OPQ_IN || cand_pri >= bus.PRI_IN);
    col_d = win ? cand_col : bus.COL_IN;
    pri_d = win ? cand_pri : bus.PRI_IN;
    opq_d = win ? 1'b1     : bus.OPQ_IN;
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      c2h_d_q <= 1'b0;
      phase_q <= 2'd0;
      layA_q  <= LRST;
      layB_q  <= LRST;
      col_q   <= '0;
      pri_q   <= '0;
      opq_q   <= 1'b0;
    end else begin
      c2h_d_q <= bus.CLK_2H;
      phase_q <= phase_d;
      layA_q  <= layA_d;
      layB_q  <= layB_d;
      col_q   <= col_d;
      pri_q   <= pri_d;
      opq_q   <= opq_d;
    end
  end

  assign bus.COL_OUT = col_q;
  assign bus.PRI_OUT = pri_q;
  assign bus.OPQ_OUT = opq_q;

endmodule

// File: tb/tb_cus43_mixer.sv
// tb_cus43_mixer: directed vector table plus reset, stuck-phase
// and optional layer-mask sequences for cus43_mixer.
module tb_cus43_mixer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   tk;

  logic [10:0] lc[32];
  logic [2:0]  lp[32];
  logic        lo[32];

  typedef struct packed {
    logic [11:0]       ga0, ga1, gb0, gb1;
    logic [7:0]        ra0, ra1, rb0, rb1;
    logic [1:0]        fa, fb;
    logic              flip;
    logic [2:0]        pa, pb;
    logic [10:0]       cin;
    logic [2:0]        pin;
    logic              oin;
    logic [0:3][10:0]  ecol;
    logic [0:3][2:0]   epri;
    logic [0:3]        eopq;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];
  vec_t base, v;

  cus43_mixer_if bus ();

  cus43_mixer dut (
    .CLK_6M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    lc[tk] = bus.COL_OUT;
    lp[tk] = bus.PRI_OUT;
    lo[tk] = bus.OPQ_OUT;
    if (tk < 31) tk++;
  endtask

  task automatic grp(input logic [11:0] ga,
                     input logic [7:0]  ra,
                     input logic [11:0] gb,
                     input logic [7:0]  rb);
    for (int t = 0; t < 4; t++) begin
      bus.CLK_2H = (t >= 2);
      bus.GD     = (t < 2) ? ga : gb;
      bus.RD     = (t < 2) ? ra : rb;
      tick();
    end
  endtask

  task automatic run_vec(input vec_t x, input int id);
    bus.FINE_A = x.fa;
    bus.FINE_B = x.fb;
    bus.FLIP   = x.flip;
    bus.PRIA   = x.pa;
    bus.PRIB   = x.pb;
    bus.COL_IN = x.cin;
    bus.PRI_IN = x.pin;
    bus.OPQ_IN = x.oin;
    tk = 0;
    grp(x.ga0, x.ra0, x.gb0, x.rb0);
    repeat (3) grp(x.ga1, x.ra1, x.gb1, x.rb1);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("v%0d_col%0d", id, p),
          32'(lc[9+p]), 32'(x.ecol[p]));
      chk($sformatf("v%0d_pri%0d", id, p),
          32'(lp[9+p]), 32'(x.epri[p]));
      chk($sformatf("v%0d_opq%0d", id, p),
          32'(lo[9+p]), 32'(x.eopq[p]));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tk    = 0;

    base      = '0;
    base.ga0  = 12'o3210;
    base.ga1  = 12'o3210;
    base.ra0  = 8'h12;
    base.ra1  = 8'h12;
    base.gb0  = 12'o7777;
    base.gb1  = 12'o7777;
    base.pa   = 3'd3;
    base.cin  = 11'h155;
    base.pin  = 3'd2;
    base.ecol = {11'h090, 11'h091, 11'h092, 11'h093};
    base.epri = {3'd3, 3'd3, 3'd3, 3'd3};
    base.eopq = 4'b1111;

    tbl[0] = base;
    v = base; v.flip = 1'b1;
    v.ecol = {11'h093, 11'h092, 11'h091, 11'h090};
    tbl[1] = v;
    v = base; v.fa = 2'd2; v.ga1 = 12'o5444; v.ra1 = 8'h34;
    v.ecol = {11'h092, 11'h093, 11'h1A4, 11'h1A4};
    tbl[2] = v;
    v = base;
    v.ga0 = 12'o1111; v.ga1 = 12'o1111;
    v.gb0 = 12'o5555; v.gb1 = 12'o5555;
    v.rb0 = 8'h56; v.rb1 = 8'h56; v.pb = 3'd3;
    v.ecol = {4{11'h091}};
    tbl[3] = v;
    v.pb = 3'd4;
    v.ecol = {4{11'h2B5}};
    v.epri = {4{3'd4}};
    tbl[4] = v;
    v.oin = 1'b1; v.pin = 3'd5;
    v.ecol = {4{11'h155}};
    v.epri = {4{3'd5}};
    tbl[5] = v;
    v.pin = 3'd4;
    v.ecol = {4{11'h2B5}};
    v.epri = {4{3'd4}};
    tbl[6] = v;
    v = base;
    v.ga0 = 12'o7777; v.ga1 = 12'o7777;
    v.cin = 11'h2AA; v.pin = 3'd1;
    v.ecol = {4{11'h2AA}};
    v.epri = {4{3'd1}};
    v.eopq = 4'b0000;
    tbl[7] = v;
    v = base; v.fa = 2'd3; v.flip = 1'b1;
    v.ga1 = 12'o5444; v.ra1 = 8'h34;
    v.ecol = {11'h090, 11'h1A5, 11'h1A4, 11'h1A4};
    tbl[8] = v;
    v = base;
    v.ga0 = 12'o7777; v.ga1 = 12'o7777;
    v.gb0 = 12'o3210; v.gb1 = 12'o6543;
    v.rb0 = 8'h01; v.rb1 = 8'h02;
    v.fb = 2'd1; v.pb = 3'd2;
    v.ecol = {11'h009, 11'h00A, 11'h00B, 11'h013};
    v.epri = {4{3'd2}};
    tbl[9] = v;
    v = base;
    v.ga0 = 12'o7070; v.ga1 = 12'o7070;
    v.gb0 = 12'o2222; v.gb1 = 12'o2222;
    v.rb0 = 8'h03; v.rb1 = 8'h03;
    v.pa = 3'd6; v.pb = 3'd1;
    v.ecol = {11'h090, 11'h01A, 11'h090, 11'h01A};
    v.epri = {3'd6, 3'd1, 3'd6, 3'd1};
    tbl[10] = v;

    rst        = 1'b1;
    bus.CLK_2H = 1'b0;
    bus.FLIP   = 1'b0;
    bus.GD     = 12'o3210;
    bus.RD     = 8'h12;
    bus.FINE_A = 2'd0;
    bus.FINE_B = 2'd0;
    bus.PRIA   = 3'd3;
    bus.PRIB   = 3'd0;
    bus.COL_IN = 11'h155;
    bus.PRI_IN = 3'd2;
    bus.OPQ_IN = 1'b1;
`ifdef CUS43_LAYER_MASK_EN
    bus.MASK_A = 1'b0;
    bus.MASK_B = 1'b0;
`endif

    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_col%0d", i), 32'(bus.COL_OUT), 32'h0);
      chk($sformatf("rst_pri%0d", i), 32'(bus.PRI_OUT), 32'h0);
      chk($sformatf("rst_opq%0d", i), 32'(bus.OPQ_OUT), 32'h0);
    end

    rst = 1'b0;
    tk  = 0;
    repeat (3) grp(12'o3210, 8'h12, 12'o7777, 8'h00);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("pass_col%0d", i), 32'(lc[i]), 32'h155);
      chk($sformatf("pass_pri%0d", i), 32'(lp[i]), 32'd2);
      chk($sformatf("pass_opq%0d", i), 32'(lo[i]), 32'd1);
    end
    chk("first_px0", 32'(lc[9]), 32'h090);
    chk("first_px1", 32'(lc[10]), 32'h091);
    chk("first_px2", 32'(lc[11]), 32'h092);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

    // CLK_2H stuck low: one boundary, then phase wraps on a fixed group
    run_vec(tbl[0], 50);
    tk         = 0;
    bus.CLK_2H = 1'b0;
    bus.GD     = 12'o3210;
    bus.RD     = 8'h12;
    repeat (9) tick();
    chk("stuck0", 32'(lc[0]), 32'h093);
    for (int k = 1; k < 9; k++)
      chk($sformatf("stuck%0d", k), 32'(lc[k]),
          32'(11'h090 + 11'((k - 1) % 4)));
    run_vec(tbl[1], 60);

    bus.COL_IN = 11'h155;
    bus.PRI_IN = 3'd2;
    bus.OPQ_IN = 1'b1;
    tk         = 0;
    bus.CLK_2H = 1'b0;
    bus.GD     = 12'o3210;
    bus.RD     = 8'h12;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_col", 32'(lc[1]), 32'h0);
    chk("mid_rst_opq", 32'(lo[1]), 32'h0);
    rst        = 1'b0;
    bus.CLK_2H = 1'b1;
    bus.GD     = 12'o7777;
    bus.RD     = 8'h00;
    tick();
    tick();
    grp(12'o3210, 8'h12, 12'o7777, 8'h00);
    grp(12'o3210, 8'h12, 12'o7777, 8'h00);
    for (int i = 2; i < 9; i++) begin
      chk($sformatf("mid_col%0d", i), 32'(lc[i]), 32'h155);
      chk($sformatf("mid_opq%0d", i), 32'(lo[i]), 32'd1);
    end

`ifdef CUS43_LAYER_MASK_EN
    bus.MASK_A = 1'b1;
    v = base;
    v.cin  = 11'h2AA;
    v.pin  = 3'd1;
    v.ecol = {4{11'h2AA}};
    v.epri = {4{3'd1}};
    v.eopq = 4'b0000;
    run_vec(v, 70);
    bus.MASK_A = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
